// File: rtl/pe_feeder.sv
// Operand sequencer in front of one PE: buffers a weight/activation vector, streams it
// into the PE one pair per cycle, then returns the accumulator delta as the dot product.
module pe_feeder #(
  parameter int W_BW   = 4,
  parameter int A_BW   = 8,
  parameter int ACC_BW = 32,
  parameter int DEPTH  = 16,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_BW-1:0]   i_weight,
  input  logic [A_BW-1:0]   i_activation,
  input  logic              i_last,
  output logic [W_BW-1:0]   o_pe_weight,
  output logic [A_BW-1:0]   o_pe_activation,
  input  logic [ACC_BW-1:0] i_pe_calculated,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [ACC_BW-1:0] o_result
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DRN_W  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam int PAIR_W = W_BW + A_BW;

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN, OUT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    rd_ptr_q;
  logic [DRN_W-1:0]    drain_cnt_q;
  logic [ACC_BW-1:0]   base_q;
  logic [ACC_BW-1:0]   result_q;
  logic                result_valid_q;
  logic [W_BW-1:0]     pe_weight_q;
  logic [A_BW-1:0]     pe_activation_q;
  logic [PAIR_W-1:0]   pair_mem [DEPTH];

  logic                accept;
  logic                load_done;
  logic                stream_done;
  logic                drain_done;
  logic [PAIR_W-1:0]   first_pair;
  logic [PAIR_W-1:0]   next_pair;

  assign accept      = i_valid && (state_q == LOAD);
  assign load_done   = accept && (i_last || (count_q == CNT_W'(DEPTH - 1)));
  assign stream_done = (state_q == STREAM) && (rd_ptr_q == count_q);
  assign drain_done  = (state_q == DRAIN) && (drain_cnt_q == DRN_W'(PE_LAT - 1));

  // A one-pair vector has not reached the buffer yet when STREAM is entered.
  assign first_pair = (count_q == '0) ? {i_weight, i_activation} : pair_mem[0];
  assign next_pair  = pair_mem[rd_ptr_q[IDX_W-1:0]];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (load_done)      state_d = STREAM;
      STREAM:  if (stream_done)    state_d = DRAIN;
      DRAIN:   if (drain_done)     state_d = OUT;
      OUT:     if (i_result_ready) state_d = LOAD;
      default:                     state_d = LOAD;
    endcase
  end

  // Output logic.
  always_comb begin
    o_ready         = (state_q == LOAD);
    o_pe_weight     = pe_weight_q;
    o_pe_activation = pe_activation_q;
    o_result        = result_q;
    o_result_valid  = result_valid_q;
  end

  // NOTE: the pair buffer has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) pair_mem[count_q[IDX_W-1:0]] <= {i_weight, i_activation};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q         <= '0;
      rd_ptr_q        <= '0;
      drain_cnt_q     <= '0;
      base_q          <= '0;
      result_q        <= '0;
      result_valid_q  <= 1'b0;
      pe_weight_q     <= '0;
      pe_activation_q <= '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) count_q <= count_q + CNT_W'(1);
          if (load_done) begin
            {pe_weight_q, pe_activation_q} <= first_pair;
            rd_ptr_q <= CNT_W'(1);
          end
        end
        STREAM: begin
          // Operands have been zero until now, so the PE output is the pre-vector accumulator.
          if (rd_ptr_q == CNT_W'(1)) base_q <= i_pe_calculated;
          if (stream_done) begin
            pe_weight_q     <= '0;
            pe_activation_q <= '0;
            drain_cnt_q     <= '0;
          end else begin
            {pe_weight_q, pe_activation_q} <= next_pair;
            rd_ptr_q <= rd_ptr_q + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            result_q       <= i_pe_calculated - base_q;
            result_valid_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRN_W'(1);
          end
        end
        OUT: begin
          if (i_result_ready) begin
            result_valid_q <= 1'b0;
            count_q        <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: a registered PE model closes the loop, a table of
// short vectors is replayed, and hand sequences cover full buffer, backpressure and reset.
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_weight;
  logic [7:0]  i_activation;
  logic        i_last;
  logic [3:0]  o_pe_weight;
  logic [7:0]  o_pe_activation;
  logic [31:0] acc;
  logic        o_result_valid;
  logic        i_result_ready;
  logic [31:0] o_result;

  logic        preset_en;
  logic [31:0] preset_val;
  logic [31:0] res_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [2:0]       n;
    logic             preset;
    logic [3:0][3:0]  w;
    logic [3:0][7:0]  a;
    logic [31:0]      exp_result;
  } vec_t;

  vec_t vecs [5];

  pe_feeder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_weight        (i_weight),
    .i_activation    (i_activation),
    .i_last          (i_last),
    .o_pe_weight     (o_pe_weight),
    .o_pe_activation (o_pe_activation),
    .i_pe_calculated (acc),
    .o_result_valid  (o_result_valid),
    .i_result_ready  (i_result_ready),
    .o_result        (o_result)
  );

  always #5 clk = ~clk;

  // PE model: registered unsigned multiply-accumulate, never cleared.
  always @(posedge clk) begin
    if (preset_en) acc <= preset_val;
    else           acc <= acc + 32'(o_pe_weight) * 32'(o_pe_activation);
  end

  always @(negedge clk) begin
    if (reset_n && o_result_valid && i_result_ready) res_q.push_back(o_result);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge, inputs still driven.
  task automatic push(input logic [3:0] w, input logic [7:0] a, input logic last);
    int t;
    i_valid = 1'b1; i_weight = w; i_activation = a; i_last = last;
    t = 0;
    while (!o_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!o_result_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    int base_idx;
    logic [31:0] hold_acc;

    vecs[0] = '{3'd3, 1'b0, {4'd0, 4'd3, 4'd2, 4'd1},   {8'd0, 8'd3, 8'd2, 8'd1},         32'd14};
    vecs[1] = '{3'd1, 1'b1, {4'd0, 4'd0, 4'd0, 4'd15},  {8'd0, 8'd0, 8'd0, 8'd255},       32'd3825};
    vecs[2] = '{3'd2, 1'b0, {4'd0, 4'd0, 4'd15, 4'd0},  {8'd0, 8'd0, 8'd1, 8'd200},       32'd15};
    vecs[3] = '{3'd4, 1'b0, {4'd15, 4'd15, 4'd15, 4'd15}, {8'd255, 8'd255, 8'd255, 8'd255}, 32'd15300};
    vecs[4] = '{3'd3, 1'b0, {4'd0, 4'd1, 4'd0, 4'd7},   {8'd0, 8'd1, 8'd9, 8'd0},         32'd1};

    reset_n = 1'b0; i_valid = 1'b0; i_weight = '0; i_activation = '0; i_last = 1'b0;
    i_result_ready = 1'b1; preset_en = 1'b1; preset_val = '0;
    repeat (3) @(negedge clk);
    preset_en = 1'b0;
    reset_n   = 1'b1;
    check("rst_ready",  {31'd0, o_ready}, 32'd1);
    check("rst_valid",  {31'd0, o_result_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_pe_w",   32'(o_pe_weight), 32'd0);
    check("rst_pe_a",   32'(o_pe_activation), 32'd0);

    // Table of short vectors: per-cycle PE operands, latency and result.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].preset) begin
        preset_en = 1'b1; preset_val = 32'hFFFF_FFF0;
        @(negedge clk);
        preset_en = 1'b0;
      end
      for (int i = 0; i < int'(vecs[v].n); i++)
        push(vecs[v].w[i], vecs[v].a[i], i == int'(vecs[v].n) - 1);
      i_valid = 1'b0; i_last = 1'b0;
      check("busy_ready", {31'd0, o_ready}, 32'd0);
      k = 0;
      while (!o_result_valid && k < 60) begin
        if (k < int'(vecs[v].n)) begin
          check("stream_w", 32'(o_pe_weight), 32'(vecs[v].w[k]));
          check("stream_a", 32'(o_pe_activation), 32'(vecs[v].a[k]));
        end else begin
          check("drain_w", 32'(o_pe_weight), 32'd0);
          check("drain_a", 32'(o_pe_activation), 32'd0);
        end
        @(negedge clk);
        k++;
      end
      check("latency", k, 32'(vecs[v].n) + 32'd1);
      check("result",  o_result, vecs[v].exp_result);
      @(negedge clk);
      check("ack_valid", {31'd0, o_result_valid}, 32'd0);
      check("ack_ready", {31'd0, o_ready}, 32'd1);
      check("ack_result_kept", o_result, vecs[v].exp_result);
    end

    // Full buffer without i_last: the 16th pair (w=0) ends the load.
    for (int i = 1; i <= 16; i++) push(4'(i), 8'(i), 1'b0);
    i_valid = 1'b0;
    check("full_ready_low", {31'd0, o_ready}, 32'd0);
    wait_valid(k);
    check("full_latency", k, 32'd17);
    check("full_result", o_result, 32'd1240);
    @(negedge clk);

    // Backpressure: result held while the reader stalls.
    i_result_ready = 1'b0;
    push(4'd5, 8'd6, 1'b1);
    i_valid = 1'b0; i_last = 1'b0;
    wait_valid(k);
    check("bp_result", o_result, 32'd30);
    hold_acc = acc;
    for (int c = 0; c < 10; c++) begin
      // i_last without a handshake must be ignored.
      i_last = 1'b1;
      @(negedge clk);
      check("bp_valid",  {31'd0, o_result_valid}, 32'd1);
      check("bp_hold",   o_result, 32'd30);
      check("bp_ready",  {31'd0, o_ready}, 32'd0);
      check("bp_pe",     {20'd0, o_pe_weight, o_pe_activation}, 32'd0);
      check("bp_acc",    acc, hold_acc);
    end
    i_last = 1'b0;
    i_result_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", {31'd0, o_result_valid}, 32'd0);
    check("bp_rel_ready", {31'd0, o_ready}, 32'd1);

    // Back-to-back vectors with i_valid held high.
    base_idx = res_q.size();
    push(4'd2, 8'd10, 1'b1);
    push(4'd1, 8'd7, 1'b0);
    push(4'd4, 8'd3, 1'b1);
    i_valid = 1'b0; i_last = 1'b0;
    k = 0;
    while (res_q.size() < base_idx + 2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("b2b_count", res_q.size(), base_idx + 2);
    if (res_q.size() >= base_idx + 2) begin
      check("b2b_first",  res_q[base_idx],     32'd20);
      check("b2b_second", res_q[base_idx + 1], 32'd19);
    end
    @(negedge clk);

    // Reset in STREAM cycle 2 of a 5-pair vector.
    for (int i = 0; i < 5; i++) push(4'd1, 8'd1, i == 4);
    i_valid = 1'b0; i_last = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_w", 32'(o_pe_weight), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_pe",    {20'd0, o_pe_weight, o_pe_activation}, 32'd0);
    check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    check("mid_rst_valid", {31'd0, o_result_valid}, 32'd0);
    push(4'd3, 8'd3, 1'b1);
    i_valid = 1'b0; i_last = 1'b0;
    wait_valid(k);
    check("post_rst_latency", k, 32'd2);
    check("post_rst_result", o_result, 32'd9);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
Name: pe_feeder

Overview:
Operand sequencer that sits in front of one pe instance.
- Accepts a vector of weight/activation pairs from an upstream writer over a valid/ready handshake and stores it in a local buffer.
- Streams the stored pairs into the PE one per cycle.
- Waits for the PE pipeline to settle, then returns that vector's dot product to a downstream reader over a valid/ready handshake.
- The PE accumulator is never cleared by this block. The per-vector result is the accumulator difference across the vector, so the PE needs no extra control port.

Parameters:
W_BW, 4, weight width (matches pe i_weight)
A_BW, 8, activation width (matches pe i_activation)
ACC_BW, 32, accumulator/result width (matches pe o_calculated)
DEPTH, 16, max pairs per vector (buffer entries)
PE_LAT, 1, cycles from operand presented at pe input to its effect visible on o_calculated

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
i_valid  input  1  upstream pair valid
o_ready  output  1  block can accept a pair
i_weight  input  W_BW  upstream weight
i_activation  input  A_BW  upstream activation
i_last  input  1  qualifies final pair of vector (sampled with i_valid&&o_ready)
o_pe_weight  output  W_BW  registered weight to pe i_weight
o_pe_activation  output  A_BW  registered activation to pe i_activation
i_pe_calculated  input  ACC_BW  pe o_calculated
o_result_valid  output  1  result available
i_result_ready  input  1  downstream accepts result
o_result  output  ACC_BW  vector dot product, unsigned, mod 2^ACC_BW

Behaviour:
- Clock and reset: single clock clk. reset_n is synchronous and active-low.
- Reset values:
  - state=LOAD, count=0, rd_ptr=0, base=0.
  - o_ready=1, o_pe_weight=0, o_pe_activation=0, o_result_valid=0, o_result=0.
  - Buffer contents are don't-care.
- Reset mid-operation: reset_n low in any state takes effect at that edge. Any partial vector or pending result is discarded.
- States: LOAD, STREAM, DRAIN, OUT. o_pe_* = 0 in every state except STREAM, so the PE accumulator holds its value.
- LOAD:
  - o_ready = 1 exactly while in LOAD.
  - Each edge with i_valid&&o_ready writes {i_weight, i_activation} to buf[count] and increments count.
  - Load ends on an accepted pair with i_last=1, or on the accepted pair that makes count=DEPTH (implicit last).
  - On load end, the same edge moves to STREAM and loads o_pe_* with buf[0]; the just-accepted pair is forwarded directly when count was 0.
  - i_valid=0 in LOAD: no change.
- STREAM:
  - Lasts exactly N=count cycles. In STREAM cycle k (k=0..N-1), o_pe_* = buf[k].
  - In cycle 0, base <= i_pe_calculated. At least one zero-operand cycle preceded STREAM, and PE_LAT>=1, so this value is the pre-vector accumulator.
  - At the end of cycle N-1: o_pe_* <= 0, go to DRAIN.
- DRAIN:
  - Lasts PE_LAT cycles.
  - On the last DRAIN edge: o_result <= i_pe_calculated - base (ACC_BW-bit wrap-around subtraction), o_result_valid <= 1, go to OUT.
- OUT:
  - o_result and o_result_valid are held stable until i_result_ready=1.
  - On that edge: o_result_valid <= 0, count <= 0, go to LOAD. o_result keeps its last value.
  - No new pairs are accepted during STREAM, DRAIN or OUT (o_ready=0).
- Latency: o_result_valid rises N+PE_LAT edges after the final-pair handshake edge.
- Arithmetic: unsigned throughout. The product fits W_BW+A_BW bits. The result is correct mod 2^ACC_BW even when the PE accumulator wraps during the vector.
- i_last on a non-handshake cycle is ignored.

Test Plan (bench models pe as acc <= acc + w*a, unsigned, registered, PE_LAT=1):
- Basic: pairs (1,1),(2,2),(3,3), i_last on third, i_result_ready=1 -> o_result=14; o_result_valid high 4 edges after last handshake; o_pe_* show 1,2,3 then 0.
- Full buffer, no i_last: 16 pairs w=i[3:0], a=i for i=1..16 -> o_ready drops after the 16th; o_result=1240 (the 16th pair has w=0).
- Backpressure: i_result_ready=0 for 10 cycles after valid -> o_result/o_result_valid stable, o_ready=0, o_pe_*=0, model acc unchanged; then ready=1 for 1 cycle -> valid low, o_ready=1 next cycle.
- Wrap-around: model acc preset to 0xFFFF_FFF0, single pair (15,255) with i_last -> o_result=3825 (0x0EF1).
- Back-to-back vectors: (2,10) last, then (1,7),(4,3) last with i_valid held high -> results 20 then 19; the accumulator is not cleared between vectors.
- Reset mid-STREAM: 5-pair vector, reset_n=0 for one edge during STREAM cycle 2 -> next cycle o_pe_*=0, o_ready=1, o_result_valid=0; a following vector (3,3) last -> o_result=9.
